// File: rtl/ras_commit_ctrl_pkg.sv
// Shared constants, types and helpers for the RAS commit controller.
package ras_commit_ctrl_pkg;

  localparam int STACKDEEP    = 16;
  localparam int STACKPTRW    = 4;
  localparam int STACKWIDE    = 32;
  localparam int RECURCOUNT   = 7;
  localparam int ENTRY_W      = STACKWIDE + RECURCOUNT;
  // The top slot of the shadow is never used, so only 15 entries are reloadable.
  localparam int RELOAD_DEPTH = STACKDEEP - 1;
  localparam int LINES_W      = RELOAD_DEPTH * ENTRY_W;

  typedef struct packed {
    logic [RECURCOUNT-1:0] count;
    logic [STACKWIDE-1:0]  addr;
  } ras_entry_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_RELOAD = 1'b1
  } ras_state_e;

  // Recursion counter increment that sticks at all-ones.
  function automatic logic [RECURCOUNT-1:0] count_sat_inc(input logic [RECURCOUNT-1:0] c);
    return (c == {RECURCOUNT{1'b1}}) ? c : c + RECURCOUNT'(1);
  endfunction

endpackage

// File: rtl/ras_commit_ctrl_shadow.sv
// Committed (architectural) copy of the return-address stack, updated by retiring calls/returns.
module ras_shadow_stack
  import ras_commit_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmt_call_valid,
  input  logic [STACKWIDE-1:0] cmt_call_addr,
  input  logic                 cmt_ret_valid,
  input  logic                 in_reload,
  output logic [STACKPTRW-1:0] ptr,
  output logic [LINES_W-1:0]   lines,
  output logic                 err_pulse
);

  ras_entry_t           entry_q [RELOAD_DEPTH];
  ras_entry_t           entry_d [RELOAD_DEPTH];
  logic [STACKPTRW-1:0] ptr_q;
  logic [STACKPTRW-1:0] ptr_d;
  logic [STACKPTRW-1:0] top_idx;
  ras_entry_t           top_ent;
  logic                 ptr_full;

  assign ptr_full = (ptr_q == STACKPTRW'(RELOAD_DEPTH));
  assign ptr      = ptr_q;

  // Pick entry[P-1]; with P==0 the index wraps to 15, which matches nothing and yields zero.
  always_comb begin
    top_idx = ptr_q - STACKPTRW'(1);
    top_ent = '0;
    for (int i = 0; i < RELOAD_DEPTH; i++) begin
      if (STACKPTRW'(i) == top_idx) top_ent = entry_q[i];
    end
  end

  // Commit update: a return wins over a simultaneous call; a matching call bumps the slot above top.
  always_comb begin
    ptr_d     = ptr_q;
    entry_d   = entry_q;
    err_pulse = 1'b0;
    if (cmt_ret_valid) begin
      if (cmt_call_valid) err_pulse = 1'b1;
      if (ptr_q == '0) begin
        err_pulse = 1'b1;
      end else begin
        for (int i = 0; i < RELOAD_DEPTH; i++) begin
          if (STACKPTRW'(i) == top_idx) begin
            if (entry_q[i].count > RECURCOUNT'(1)) begin
              entry_d[i].count = entry_q[i].count - RECURCOUNT'(1);
            end else begin
              entry_d[i] = '0;
            end
          end
        end
        if (top_ent.count <= RECURCOUNT'(1)) ptr_d = ptr_q - STACKPTRW'(1);
      end
    end else if (cmt_call_valid) begin
      if ((ptr_q != '0) && (top_ent.addr == cmt_call_addr)) begin
        // Slot P does not exist once the stack is full, so the bump is a no-op there.
        for (int i = 0; i < RELOAD_DEPTH; i++) begin
          if (STACKPTRW'(i) == ptr_q) begin
            entry_d[i].count = count_sat_inc(entry_q[i].count);
            entry_d[i].addr  = cmt_call_addr;
          end
        end
      end else if (ptr_full) begin
        err_pulse = 1'b1;
      end else begin
        for (int i = 0; i < RELOAD_DEPTH; i++) begin
          if (STACKPTRW'(i) == ptr_q) begin
            entry_d[i].count = RECURCOUNT'(1);
            entry_d[i].addr  = cmt_call_addr;
          end
        end
        ptr_d = ptr_q + STACKPTRW'(1);
      end
    end
    // Retirement during the reload cycle is a pipeline protocol violation.
    if (in_reload && (cmt_call_valid || cmt_ret_valid)) err_pulse = 1'b1;
  end

  // Shadow registers; cleared on reset so the first reload after reset is an empty stack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < RELOAD_DEPTH; i++) entry_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < RELOAD_DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

  // Flatten entries so entry i sits at bits [i*ENTRY_W +: ENTRY_W].
  always_comb begin
    lines = '0;
    for (int i = 0; i < RELOAD_DEPTH; i++) begin
      lines[i*ENTRY_W +: ENTRY_W] = entry_q[i];
    end
  end

endmodule

// File: rtl/ras_commit_ctrl.sv
// RAS controller: front-end arbitration, flush/reload sequencing and sticky error tracking.
module ras_commit_ctrl
  import ras_commit_ctrl_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rest,
  input  logic                 FeCallValid,
  input  logic [STACKWIDE-1:0] FeCallAddr,
  input  logic                 FeRetValid,
  output logic                 FeStall,
  output logic                 RasWable,
  output logic [STACKWIDE-1:0] RasDin,
  output logic                 RasRable,
  input  logic                 CmtCallValid,
  input  logic [STACKWIDE-1:0] CmtCallAddr,
  input  logic                 CmtRetValid,
  input  logic                 Flush,
  output logic                 RasReload,
  output logic [STACKPTRW-1:0] RasReloadPtr,
  output logic [LINES_W-1:0]   RasReloadLines,
  output logic                 Err
);

  ras_state_e state_q;
  ras_state_e state_d;
  logic       reload_q;
  logic       err_q;
  logic       err_d;
  logic       stall;
  logic       fe_conflict;
  logic       shadow_err;

  ras_shadow_stack u_shadow (
    .clk            (Clk),
    .rst_n          (Rest),
    .cmt_call_valid (CmtCallValid),
    .cmt_call_addr  (CmtCallAddr),
    .cmt_ret_valid  (CmtRetValid),
    .in_reload      (state_q == ST_RELOAD),
    .ptr            (RasReloadPtr),
    .lines          (RasReloadLines),
    .err_pulse      (shadow_err)
  );

  // Front-end traffic passes straight through unless a flush is requested or a reload is in flight.
  always_comb begin
    stall       = Flush | (state_q == ST_RELOAD);
    FeStall     = stall;
    RasWable    = ~stall & FeCallValid;
    RasDin      = FeCallAddr;
    RasRable    = ~stall & FeRetValid & ~FeCallValid;
    fe_conflict = ~stall & FeCallValid & FeRetValid;
  end

  // Next state: any flush (including one during reload) schedules a reload cycle.
  always_comb begin
    state_d = Flush ? ST_RELOAD : ST_RUN;
    err_d   = err_q | fe_conflict | shadow_err;
  end

  // FSM state plus registered reload strobe and sticky error.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q  <= ST_RUN;
      reload_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= (state_d == ST_RELOAD);
      err_q    <= err_d;
    end
  end

  assign RasReload = reload_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_ras_commit_ctrl.sv
// Directed and randomized bench for ras_commit_ctrl with a behavioural shadow-stack model.
module tb_ras_commit_ctrl;
  import ras_commit_ctrl_pkg::*;

  logic                 Clk = 1'b0;
  logic                 Rest = 1'b1;
  logic                 FeCallValid = 1'b0;
  logic [STACKWIDE-1:0] FeCallAddr = '0;
  logic                 FeRetValid = 1'b0;
  logic                 FeStall;
  logic                 RasWable;
  logic [STACKWIDE-1:0] RasDin;
  logic                 RasRable;
  logic                 CmtCallValid = 1'b0;
  logic [STACKWIDE-1:0] CmtCallAddr = '0;
  logic                 CmtRetValid = 1'b0;
  logic                 Flush = 1'b0;
  logic                 RasReload;
  logic [STACKPTRW-1:0] RasReloadPtr;
  logic [LINES_W-1:0]   RasReloadLines;
  logic                 Err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: committed stack as plain arrays + pointer, and a reload flag.
  logic [STACKWIDE-1:0] m_addr [RELOAD_DEPTH];
  int unsigned          m_cnt  [RELOAD_DEPTH];
  int unsigned          m_ptr;
  bit                   m_reload;
  bit                   m_err;

  ras_commit_ctrl dut (
    .Clk            (Clk),
    .Rest           (Rest),
    .FeCallValid    (FeCallValid),
    .FeCallAddr     (FeCallAddr),
    .FeRetValid     (FeRetValid),
    .FeStall        (FeStall),
    .RasWable       (RasWable),
    .RasDin         (RasDin),
    .RasRable       (RasRable),
    .CmtCallValid   (CmtCallValid),
    .CmtCallAddr    (CmtCallAddr),
    .CmtRetValid    (CmtRetValid),
    .Flush          (Flush),
    .RasReload      (RasReload),
    .RasReloadPtr   (RasReloadPtr),
    .RasReloadLines (RasReloadLines),
    .Err            (Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [LINES_W-1:0] obs, input logic [LINES_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINES_W-1:0] exp_lines();
    logic [LINES_W-1:0] v;
    v = '0;
    for (int i = 0; i < RELOAD_DEPTH; i++)
      v[i*ENTRY_W +: ENTRY_W] = {m_cnt[i][RECURCOUNT-1:0], m_addr[i]};
    return v;
  endfunction

  function automatic logic [ENTRY_W-1:0] ent(input int unsigned c, input logic [STACKWIDE-1:0] a);
    return {c[RECURCOUNT-1:0], a};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RELOAD_DEPTH; i++) begin
      m_addr[i] = '0;
      m_cnt[i]  = 0;
    end
    m_ptr    = 0;
    m_reload = 1'b0;
    m_err    = 1'b0;
  endtask

  // Apply one retirement to the model stack.
  task automatic model_commit(input bit c, input logic [STACKWIDE-1:0] a, input bit r);
    if (r) begin
      if (c) m_err = 1'b1;
      if (m_ptr == 0) m_err = 1'b1;
      else if (m_cnt[m_ptr-1] > 1) m_cnt[m_ptr-1] = m_cnt[m_ptr-1] - 1;
      else begin
        m_cnt[m_ptr-1]  = 0;
        m_addr[m_ptr-1] = '0;
        m_ptr = m_ptr - 1;
      end
    end else if (c) begin
      if (m_ptr != 0 && m_addr[m_ptr-1] == a) begin
        if (m_ptr < RELOAD_DEPTH) begin
          m_cnt[m_ptr]  = (m_cnt[m_ptr] >= 127) ? 127 : m_cnt[m_ptr] + 1;
          m_addr[m_ptr] = a;
        end
      end else if (m_ptr == RELOAD_DEPTH) begin
        m_err = 1'b1;
      end else begin
        m_cnt[m_ptr]  = 1;
        m_addr[m_ptr] = a;
        m_ptr = m_ptr + 1;
      end
    end
  endtask

  task automatic model_clock();
    bit st;
    st = Flush || m_reload;
    if (!st && FeCallValid && FeRetValid) m_err = 1'b1;
    if (m_reload && (CmtCallValid || CmtRetValid)) m_err = 1'b1;
    model_commit(CmtCallValid, CmtCallAddr, CmtRetValid);
    m_reload = Flush;
  endtask

  task automatic check_comb(input string tag);
    bit st;
    st = Flush || m_reload;
    chk({tag, "_festall"}, LINES_W'(FeStall), LINES_W'(st));
    chk({tag, "_wable"}, LINES_W'(RasWable), LINES_W'(!st && FeCallValid));
    chk({tag, "_rable"}, LINES_W'(RasRable), LINES_W'(!st && FeRetValid && !FeCallValid));
    if (!st && FeCallValid) chk({tag, "_din"}, LINES_W'(RasDin), LINES_W'(FeCallAddr));
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_ptr"}, LINES_W'(RasReloadPtr), LINES_W'(m_ptr));
    chk({tag, "_lines"}, RasReloadLines, exp_lines());
    chk({tag, "_reload"}, LINES_W'(RasReload), LINES_W'(m_reload));
    chk({tag, "_err"}, LINES_W'(Err), LINES_W'(m_err));
  endtask

  // One clock: inputs already driven at a negedge; check comb, clock, check registers.
  task automatic cycle(input string tag);
    #1;
    check_comb(tag);
    @(posedge Clk);
    model_clock();
    @(negedge Clk);
    check_regs(tag);
  endtask

  task automatic idle_inputs();
    FeCallValid  = 1'b0;
    FeCallAddr   = '0;
    FeRetValid   = 1'b0;
    CmtCallValid = 1'b0;
    CmtCallAddr  = '0;
    CmtRetValid  = 1'b0;
    Flush        = 1'b0;
  endtask

  task automatic set_cmt(input bit c, input logic [STACKWIDE-1:0] a, input bit r);
    CmtCallValid = c;
    CmtCallAddr  = a;
    CmtRetValid  = r;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs are checked before any clock edge.
  task automatic do_reset(input string tag);
    idle_inputs();
    Rest = 1'b0;
    #1;
    chk({tag, "_rst_festall"}, LINES_W'(FeStall), '0);
    chk({tag, "_rst_wable"}, LINES_W'(RasWable), '0);
    chk({tag, "_rst_rable"}, LINES_W'(RasRable), '0);
    chk({tag, "_rst_reload"}, LINES_W'(RasReload), '0);
    chk({tag, "_rst_err"}, LINES_W'(Err), '0);
    chk({tag, "_rst_ptr"}, LINES_W'(RasReloadPtr), '0);
    chk({tag, "_rst_lines"}, RasReloadLines, '0);
    model_reset();
    @(negedge Clk);
    Rest = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    @(negedge Clk);
    do_reset("t0");

    // 1: two distinct commit calls
    set_cmt(1, 32'h1000, 0); cycle("t1a");
    set_cmt(1, 32'h2000, 0); cycle("t1b");
    idle_inputs();
    chk("t1_ptr", LINES_W'(RasReloadPtr), LINES_W'(2));
    chk("t1_line0", LINES_W'(RasReloadLines[0 +: ENTRY_W]), LINES_W'(ent(1, 32'h1000)));
    chk("t1_line1", LINES_W'(RasReloadLines[ENTRY_W +: ENTRY_W]), LINES_W'(ent(1, 32'h2000)));
    chk("t1_err", LINES_W'(Err), '0);

    // 2: recursive call bumps slot P, then return pops
    do_reset("t2");
    set_cmt(1, 32'h1000, 0); cycle("t2a");
    set_cmt(1, 32'h1000, 0); cycle("t2b");
    chk("t2_ptr", LINES_W'(RasReloadPtr), LINES_W'(1));
    chk("t2_line1", LINES_W'(RasReloadLines[ENTRY_W +: ENTRY_W]), LINES_W'(ent(1, 32'h1000)));
    set_cmt(0, '0, 1); cycle("t2c");
    idle_inputs();
    chk("t2_ptr_pop", LINES_W'(RasReloadPtr), '0);
    chk("t2_line0_pop", LINES_W'(RasReloadLines[0 +: ENTRY_W]), '0);

    // 3: front-end pass-through, then flush stall and one reload cycle
    FeCallValid = 1; FeCallAddr = 32'h3000; cycle("t3a");
    Flush = 1; cycle("t3b");
    chk("t3_reload", LINES_W'(RasReload), LINES_W'(1));
    Flush = 0; cycle("t3c");
    chk("t3_reload_end", LINES_W'(RasReload), '0);
    #1;
    chk("t3_festall_run", LINES_W'(FeStall), '0);
    chk("t3_wable_run", LINES_W'(RasWable), LINES_W'(1));
    idle_inputs();

    // 4: commit in the flush cycle is visible in the reload
    do_reset("t4");
    Flush = 1; set_cmt(1, 32'h4000, 0); cycle("t4a");
    idle_inputs();
    chk("t4_reload", LINES_W'(RasReload), LINES_W'(1));
    chk("t4_ptr", LINES_W'(RasReloadPtr), LINES_W'(1));
    chk("t4_line0", LINES_W'(RasReloadLines[0 +: ENTRY_W]), LINES_W'(ent(1, 32'h4000)));
    cycle("t4b");

    // 5: overflow and underflow
    do_reset("t5");
    for (int i = 0; i < 15; i++) begin
      set_cmt(1, 32'h100 * (i + 1), 0); cycle("t5fill");
    end
    set_cmt(1, 32'hDEAD0, 0); cycle("t5ovf");
    idle_inputs();
    chk("t5_ptr_full", LINES_W'(RasReloadPtr), LINES_W'(15));
    chk("t5_err_ovf", LINES_W'(Err), LINES_W'(1));
    do_reset("t5u");
    set_cmt(0, '0, 1); cycle("t5unf");
    idle_inputs();
    chk("t5_err_unf", LINES_W'(Err), LINES_W'(1));

    // recursion counter saturation on slot P
    do_reset("tsat");
    for (int i = 0; i < 132; i++) begin
      set_cmt(1, 32'h5000, 0); cycle("tsat");
    end
    idle_inputs();
    chk("tsat_count", LINES_W'(RasReloadLines[ENTRY_W +: ENTRY_W]), LINES_W'(ent(127, 32'h5000)));

    // 6: held flush, then reset during reload
    do_reset("t6");
    Flush = 1;
    for (int i = 0; i < 3; i++) cycle("t6hold");
    Flush = 0; cycle("t6tail");
    Flush = 1; cycle("t6again");
    chk("t6_in_reload", LINES_W'(RasReload), LINES_W'(1));
    do_reset("t6mid");

    // random phase
    for (int e = 0; e < 5; e++) begin
      do_reset("rnd");
      for (int n = 0; n < 60; n++) begin
        FeCallValid  = ($urandom_range(0, 3) == 0);
        FeRetValid   = ($urandom_range(0, 3) == 0);
        FeCallAddr   = $urandom;
        CmtCallValid = ($urandom_range(0, 9) < 4);
        CmtRetValid  = ($urandom_range(0, 9) < 3);
        CmtCallAddr  = 32'h100 * $urandom_range(1, 4);
        Flush        = ($urandom_range(0, 9) == 0);
        cycle("rnd");
      end
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
